// File: rtl/aes_sbox_pkg.sv
// Shared types for the S-box lane arbiter: lane geometry, owners, FSM states and the in-flight tag.
package aes_sbox_pkg;

  localparam int LANES           = 4;
  localparam int BEATS_PER_STATE = 4;

  localparam logic [1:0] LAST_ST_BEAT = 2'(BEATS_PER_STATE - 1);

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_KW = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST_ISSUE = 2'd1,
    KW_ISSUE = 2'd2
  } fsm_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic [1:0] beat;
  } tag_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// SBOX_LAT-deep tag shift register tracking which beat sits in each S-box lane stage.
// Latency SBOX_LAT cycles, no backpressure; rst clears every stage so in-flight results are dropped.
module sbox_tag_pipe
  import aes_sbox_pkg::*;
#(
  parameter int SBOX_LAT = 6
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [SBOX_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < SBOX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[SBOX_LAT-1];

endmodule

// File: rtl/sbox_share_arbiter.sv
// Shares one 4-lane S-box pipe between state SubBytes (4 beats) and key SubWord (1 beat); done at T+5+SBOX_LAT / T+2+SBOX_LAT.
// One job per requester (ready low until the cycle after done); KEY_PRIORITY_EN selects fixed key priority instead of round-robin.
module sbox_share_arbiter
  import aes_sbox_pkg::*;
#(
  parameter int SBOX_LAT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_req_valid,
  output logic                 st_req_ready,
  input  logic [127:0]         st_data_in,
  output logic                 st_done,
  output logic [127:0]         st_data_out,
  input  logic                 kw_req_valid,
  output logic                 kw_req_ready,
  input  logic [31:0]          kw_data_in,
  output logic                 kw_done,
  output logic [31:0]          kw_data_out,
  output logic [8*LANES-1:0]   sbox_in,
  input  logic [8*LANES-1:0]   sbox_out
);

  fsm_e         state_q;
  logic [1:0]   beat_q;
  logic         st_busy_q, kw_busy_q;
  logic         st_pend_q, kw_pend_q;
  logic [127:0] st_buf_q;
  logic [31:0]  kw_buf_q;
  logic [31:0]  sbox_in_q;
  tag_t         issue_tag_q;
  tag_t         exit_tag;
  logic [95:0]  st_coll_q;
  logic         st_done_q, kw_done_q;
  logic [127:0] st_data_out_q;
  logic [31:0]  kw_data_out_q;

  logic         st_acc, kw_acc, st_cand, kw_cand, grant_st, grant_kw;
  logic [127:0] st_src;
  logic [31:0]  kw_src;
  logic [1:0]   beat_d;

  assign st_req_ready = ~st_busy_q & ~rst;
  assign kw_req_ready = ~kw_busy_q & ~rst;
  assign st_acc       = st_req_valid & st_req_ready;
  assign kw_acc       = kw_req_valid & kw_req_ready;

  // A job being accepted this cycle is already a candidate, so it can issue on the next cycle.
  assign st_cand = st_pend_q | st_acc;
  assign kw_cand = kw_pend_q | kw_acc;
  assign st_src  = st_pend_q ? st_buf_q : st_data_in;
  assign kw_src  = kw_pend_q ? kw_buf_q : kw_data_in;
  assign beat_d  = beat_q + 2'd1;

`ifdef KEY_PRIORITY_EN
  assign grant_kw = kw_cand;
`else
  owner_e rr_last_q;

  assign grant_kw = kw_cand & (~st_cand | (rr_last_q == OWN_ST));

  // Pointer moves only on contested grants, so lone jobs never disturb the fairness order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= OWN_KW;
    end else if (state_q == IDLE && st_cand && kw_cand) begin
      rr_last_q <= grant_kw ? OWN_KW : OWN_ST;
    end
  end
`endif
  assign grant_st = st_cand & ~grant_kw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      sbox_in_q   <= '0;
      issue_tag_q <= '0;
      st_pend_q   <= 1'b0;
      kw_pend_q   <= 1'b0;
      st_buf_q    <= '0;
      kw_buf_q    <= '0;
    end else begin
      if (st_acc) begin
        st_buf_q  <= st_data_in;
        st_pend_q <= 1'b1;
      end
      if (kw_acc) begin
        kw_buf_q  <= kw_data_in;
        kw_pend_q <= 1'b1;
      end
      sbox_in_q   <= '0;
      issue_tag_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_st) begin
            state_q     <= ST_ISSUE;
            beat_q      <= '0;
            st_pend_q   <= 1'b0;
            sbox_in_q   <= st_src[31:0];
            issue_tag_q <= '{valid: 1'b1, owner: OWN_ST, beat: 2'd0};
          end else if (grant_kw) begin
            state_q     <= KW_ISSUE;
            kw_pend_q   <= 1'b0;
            sbox_in_q   <= kw_src;
            issue_tag_q <= '{valid: 1'b1, owner: OWN_KW, beat: 2'd0};
          end
        end
        ST_ISSUE: begin
          if (beat_q == LAST_ST_BEAT) begin
            state_q <= IDLE;
          end else begin
            beat_q      <= beat_d;
            sbox_in_q   <= st_buf_q[{beat_d, 5'd0} +: 32];
            issue_tag_q <= '{valid: 1'b1, owner: OWN_ST, beat: beat_d};
          end
        end
        KW_ISSUE: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  sbox_tag_pipe #(
    .SBOX_LAT (SBOX_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (issue_tag_q),
    .tag_o (exit_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_busy_q     <= 1'b0;
      kw_busy_q     <= 1'b0;
      st_coll_q     <= '0;
      st_done_q     <= 1'b0;
      kw_done_q     <= 1'b0;
      st_data_out_q <= '0;
      kw_data_out_q <= '0;
    end else begin
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      if (st_acc)         st_busy_q <= 1'b1;
      else if (st_done_q) st_busy_q <= 1'b0;
      if (kw_acc)         kw_busy_q <= 1'b1;
      else if (kw_done_q) kw_busy_q <= 1'b0;
      // Final beat bypasses the collect buffer so data_out and done update on the same edge.
      if (exit_tag.valid) begin
        if (exit_tag.owner == OWN_KW) begin
          kw_done_q     <= 1'b1;
          kw_data_out_q <= sbox_out;
        end else if (exit_tag.beat == LAST_ST_BEAT) begin
          st_done_q     <= 1'b1;
          st_data_out_q <= {sbox_out, st_coll_q};
        end else begin
          st_coll_q[{exit_tag.beat, 5'd0} +: 32] <= sbox_out;
        end
      end
    end
  end

  assign sbox_in     = sbox_in_q;
  assign st_done     = st_done_q;
  assign kw_done     = kw_done_q;
  assign st_data_out = st_data_out_q;
  assign kw_data_out = kw_data_out_q;

endmodule
